vga_console_ctrl: RTL and testbench



---
 rtl/vga_console_ctrl_if.sv | 36 +++
 rtl/vga_console_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_vga_console_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_console_ctrl_if.sv
//==============================================================================
// Module      : vga_console_ctrl_if
// Description : Character stream handshake and text-buffer port bundle for
//               the VGA console write controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface vga_console_ctrl_if #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 10
);
    localparam int AW = $clog2(NUM_ROWS * NUM_COLS);

    logic          char_valid;
    logic          char_ready;
    logic [6:0]    char_data;
    logic [1:0]    char_color;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [8:0]    buf_wdata;
    logic [AW-1:0] buf_raddr;
    logic [8:0]    buf_rdata;

    modport master (
        output char_valid, char_data, char_color, buf_rdata,
        input  char_ready, buf_we, buf_waddr, buf_wdata, buf_raddr
    );

    modport slave (
        input  char_valid, char_data, char_color, buf_rdata,
        output char_ready, buf_we, buf_waddr, buf_wdata, buf_raddr
    );
endinterface

`default_nettype wire

// File: rtl/vga_console_ctrl.sv
//==============================================================================
// Module      : vga_console_ctrl
// Description : Terminal-style writer for the VGA text buffer: cursor, CR/LF/
//               BS/FF handling, line wrap, scroll and clear. Optional macro
//               CONSOLE_VBLANK_SYNC_EN holds scroll/clear until vblank.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_console_ctrl #(
    parameter int  NUM_ROWS  = 3,
    parameter int  NUM_COLS  = 10,
    localparam int NUM_CHARS = NUM_ROWS * NUM_COLS,
    localparam int AW        = $clog2(NUM_CHARS),
    localparam int RW        = $clog2(NUM_ROWS),
    localparam int CLW       = $clog2(NUM_COLS)
) (
    input  logic                clk,
    input  logic                rst,
    vga_console_ctrl_if.slave   bus,
    input  logic                vblank,
    output logic [RW-1:0]       cur_row,
    output logic [CLW-1:0]      cur_col,
    output logic                busy
);

    // Counter must reach NUM_CHARS as the end-of-sequence marker
    localparam int CW = $clog2(NUM_CHARS + 1);

    localparam logic [CW-1:0]  c_cnt_cols     = CW'(NUM_COLS);
    localparam logic [CW-1:0]  c_cnt_last_src = CW'(NUM_CHARS - 1);
    localparam logic [CW-1:0]  c_cnt_last_row = CW'(NUM_CHARS - NUM_COLS);
    localparam logic [CW-1:0]  c_cnt_end      = CW'(NUM_CHARS);
    localparam logic [CLW-1:0] c_col_last     = CLW'(NUM_COLS - 1);
    localparam logic [RW-1:0]  c_row_last     = RW'(NUM_ROWS - 1);
    localparam logic [8:0]     c_blank        = 9'h020;

`ifdef CONSOLE_VBLANK_SYNC_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCROLL  = 2'd1,
        CLEAR   = 2'd2,
        WAIT_VB = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCROLL  = 2'd1,
        CLEAR   = 2'd2
    } state_t;
`endif

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [RW-1:0]   r_row, w_row_nxt;
    logic [CLW-1:0]  r_col, w_col_nxt;
    logic            r_we, w_we_nxt;
    logic [AW-1:0]   r_waddr, w_waddr_nxt;
    logic [8:0]      r_wdata, w_wdata_nxt;

    logic            w_printable;
    logic            w_wrap;
    logic            w_go_scroll;
    logic            w_go_clear;
    logic            w_start_scroll;
    logic            w_start_clear;
    logic [AW-1:0]   w_cur_addr;

`ifdef CONSOLE_VBLANK_SYNC_EN
    logic            r_pend_clr, w_pend_clr_nxt;
`else
    logic            w_unused_vblank;
    assign w_unused_vblank = vblank;
`endif

    assign w_printable = (bus.char_data >= 7'h20) && (bus.char_data <= 7'h7E);
    assign w_cur_addr  = AW'(int'(r_row) * NUM_COLS + int'(r_col));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
`ifdef CONSOLE_VBLANK_SYNC_EN
            r_pend_clr <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_we    <= w_we_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
`ifdef CONSOLE_VBLANK_SYNC_EN
            r_pend_clr <= w_pend_clr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_we_nxt       = 1'b0;
        w_waddr_nxt    = r_waddr;
        w_wdata_nxt    = r_wdata;
        w_wrap         = 1'b0;
        w_go_scroll    = 1'b0;
        w_go_clear     = 1'b0;
        w_start_scroll = 1'b0;
        w_start_clear  = 1'b0;
`ifdef CONSOLE_VBLANK_SYNC_EN
        w_pend_clr_nxt = r_pend_clr;
`endif

        case (r_state)
            IDLE: begin
                if (bus.char_valid) begin
                    if (w_printable) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = w_cur_addr;
                        w_wdata_nxt = {bus.char_color, bus.char_data};
                        if (r_col < c_col_last) begin
                            w_col_nxt = r_col + 1'b1;
                        end else begin
                            w_wrap = 1'b1;
                        end
                    end else if (bus.char_data == 7'h0A) begin
                        w_wrap = 1'b1;
                    end else if (bus.char_data == 7'h0D) begin
                        w_col_nxt = '0;
                    end else if (bus.char_data == 7'h08) begin
                        if (r_col != '0) begin
                            w_col_nxt = r_col - 1'b1;
                        end
                    end else if (bus.char_data == 7'h0C) begin
                        w_row_nxt  = '0;
                        w_col_nxt  = '0;
                        w_go_clear = 1'b1;
                    end

                    if (w_wrap) begin
                        w_col_nxt = '0;
                        if (r_row < c_row_last) begin
                            w_row_nxt = r_row + 1'b1;
                        end else begin
                            w_go_scroll = 1'b1;
                        end
                    end
                end
            end

            // Read of cell s is presented now; its copy lands NUM_COLS lower next cycle
            SCROLL: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = AW'(r_cnt - c_cnt_cols);
                w_wdata_nxt = bus.buf_rdata;
                if (r_cnt == c_cnt_last_src) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = c_cnt_last_row;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            // The cycle with r_cnt at the end marker keeps busy high over the last write
            CLEAR: begin
                if (r_cnt == c_cnt_end) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = AW'(r_cnt);
                    w_wdata_nxt = c_blank;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end

`ifdef CONSOLE_VBLANK_SYNC_EN
            WAIT_VB: begin
                if (vblank) begin
                    w_start_clear  = r_pend_clr;
                    w_start_scroll = !r_pend_clr;
                end
            end
`endif

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

`ifdef CONSOLE_VBLANK_SYNC_EN
        if (w_go_scroll || w_go_clear) begin
            w_state_nxt    = WAIT_VB;
            w_pend_clr_nxt = w_go_clear;
        end
`else
        w_start_scroll = w_go_scroll;
        w_start_clear  = w_go_clear;
`endif

        if (w_start_scroll) begin
            w_state_nxt = SCROLL;
            w_cnt_nxt   = c_cnt_cols;
        end

        // Cell 0 is launched together with the start so clear writes begin next cycle
        if (w_start_clear) begin
            w_state_nxt = CLEAR;
            w_cnt_nxt   = CW'(1);
            w_we_nxt    = 1'b1;
            w_waddr_nxt = '0;
            w_wdata_nxt = c_blank;
        end
    end

    assign bus.char_ready = (r_state == IDLE) && !rst;
    assign busy           = (r_state != IDLE) && !rst;
    assign bus.buf_raddr  = (r_state == SCROLL) ? AW'(r_cnt) : '0;
    assign bus.buf_we     = r_we;
    assign bus.buf_waddr  = r_waddr;
    assign bus.buf_wdata  = r_wdata;
    assign cur_row        = r_row;
    assign cur_col        = r_col;

endmodule

`default_nettype wire

// File: tb/tb_vga_console_ctrl.sv
//==============================================================================
// Module      : tb_vga_console_ctrl
// Description : Scoreboard bench for vga_console_ctrl against a screen model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vga_console_ctrl;
    localparam int R  = 3;
    localparam int C  = 10;
    localparam int NC = R * C;
    localparam int AW = $clog2(NC);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vblank = 1'b0;
    logic load = 1'b1;
    logic [$clog2(R)-1:0] cur_row;
    logic [$clog2(C)-1:0] cur_col;
    logic busy;

    vga_console_ctrl_if #(.NUM_ROWS(R), .NUM_COLS(C)) bus();

    vga_console_ctrl #(.NUM_ROWS(R), .NUM_COLS(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .vblank  (vblank),
        .cur_row (cur_row),
        .cur_col (cur_col),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Text buffer seen by the DUT, seeded with the same random contents as the model
    logic [8:0] seed [2**AW];
    logic [8:0] mem  [2**AW];
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= seed[i];
        end else if (bus.buf_we) begin
            mem[bus.buf_waddr] <= bus.buf_wdata;
        end
    end
    assign bus.buf_rdata = mem[bus.buf_raddr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) vblank = 1'($urandom_range(0, 1));

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;
    wr_t q[$];

    logic [8:0] scr [NC];
    int mrow = 0;
    int mcol = 0;
    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    function automatic void exp_wr(int a, logic [8:0] d, int t);
        wr_t e;
        e.addr = a;
        e.data = int'(d);
        e.cyc  = t;
        q.push_back(e);
        scr[a] = d;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst && bus.buf_we) begin
            wr_t e;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=%h cyc=%0d, required no write",
                         bus.buf_waddr, bus.buf_wdata, cyc);
            end else begin
                e = q.pop_front();
                if (int'(bus.buf_waddr) != e.addr || int'(bus.buf_wdata) != e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL buf_write: got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             bus.buf_waddr, bus.buf_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // Called at a negedge with char_ready high; returns at the next such negedge
    task automatic send(input logic [6:0] ch, input logic [1:0] co);
        int n;
        int lo;
        int exp_lo;
        bit wrap;
        bit scroll;
        bus.char_valid = 1'b1;
        bus.char_data  = ch;
        bus.char_color = co;
        n = cyc;
        @(posedge clk);
        #1 bus.char_valid = 1'b0;

        exp_lo = 0;
        wrap   = 1'b0;
        scroll = 1'b0;
        if (ch >= 7'h20 && ch <= 7'h7E) begin
            exp_wr(mrow * C + mcol, {co, ch}, n + 1);
            if (mcol < C - 1) mcol++;
            else wrap = 1'b1;
        end else if (ch == 7'h0A) begin
            wrap = 1'b1;
        end else if (ch == 7'h0D) begin
            mcol = 0;
        end else if (ch == 7'h08) begin
            if (mcol > 0) mcol--;
        end else if (ch == 7'h0C) begin
            mrow = 0;
            mcol = 0;
            for (int i = 0; i < NC; i++) exp_wr(i, 9'h020, n + 1 + i);
            exp_lo = NC;
        end
        if (wrap) begin
            mcol = 0;
            if (mrow < R - 1) mrow++;
            else scroll = 1'b1;
        end
        if (scroll) begin
            for (int r = 0; r < R - 1; r++)
                for (int c = 0; c < C; c++)
                    exp_wr(r * C + c, scr[(r + 1) * C + c], n + 2 + r * C + c);
            for (int c = 0; c < C; c++)
                exp_wr((R - 1) * C + c, 9'h020, n + 2 + (R - 1) * C + c);
            exp_lo = NC + 1;
        end

        lo = 0;
        @(negedge clk);
        while (!bus.char_ready && lo < 200) begin
            lo++;
            @(negedge clk);
        end
        chk("ready_low_cycles", lo, exp_lo);
        chk("cur_row", int'(cur_row), mrow);
        chk("cur_col", int'(cur_col), mcol);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int v;
        int nwr;
        logic [6:0] ch;
        for (int i = 0; i < 2**AW; i++) seed[i] = 9'($urandom);
        for (int i = 0; i < NC; i++) scr[i] = seed[i];
        bus.char_valid = 1'b0;
        bus.char_data  = '0;
        bus.char_color = '0;

        repeat (3) @(negedge clk);
        chk("rst_char_ready", int'(bus.char_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_buf_we", int'(bus.buf_we), 0);
        chk("rst_buf_waddr", int'(bus.buf_waddr), 0);
        chk("rst_buf_wdata", int'(bus.buf_wdata), 0);
        chk("rst_cursor", int'({cur_row, cur_col}), 0);
        load = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        chk("idle_char_ready", int'(bus.char_ready), 1);
        mon_en = 1'b1;

        send(7'h48, 2'd1);
        send(7'h49, 2'd1);
        repeat (8) send(7'h41, 2'd0);
        repeat (5) send(7'h42, 2'd2);
        send(7'h0D, 2'd0);
        send(7'h08, 2'd0);
        send(7'h07, 2'd0);
        send(7'h7F, 2'd0);
        send(7'h0C, 2'd0);
        for (int i = 0; i < NC - 1; i++) send(7'($urandom_range(32, 126)), 2'($urandom));
        send(7'h5A, 2'd3);
        send(7'h0A, 2'd0);

        for (int k = 0; k < 300; k++) begin
            p = $urandom_range(0, 99);
            if (p < 70) ch = 7'($urandom_range(32, 126));
            else if (p < 78) ch = 7'h0A;
            else if (p < 83) ch = 7'h0D;
            else if (p < 88) ch = 7'h08;
            else if (p < 90) ch = 7'h0C;
            else begin
                v = $urandom_range(0, 32);
                if (v == 32) ch = 7'h7F;
                else if (v == 8 || v == 10 || v == 12 || v == 13) ch = 7'h07;
                else ch = 7'(v);
            end
            send(ch, 2'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        // Reset in the middle of a clear must stop writes at once
        mon_en = 1'b0;
        q.delete();
        bus.char_valid = 1'b1;
        bus.char_data  = 7'h0C;
        @(posedge clk);
        #1 bus.char_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_clear_busy", int'(busy), 1);
        chk("mid_clear_we", int'(bus.buf_we), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we", int'(bus.buf_we), 0);
        chk("abort_ready_in_rst", int'(bus.char_ready), 0);
        chk("abort_busy_in_rst", int'(busy), 0);
        rst = 1'b0;
        nwr = 0;
        @(negedge clk);
        chk("abort_ready", int'(bus.char_ready), 1);
        chk("abort_cursor", int'({cur_row, cur_col}), 0);
        repeat (40) begin
            if (bus.buf_we) nwr++;
            @(negedge clk);
        end
        chk("abort_no_writes", nwr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
